// File: rtl/input_conditioner_pkg.sv
// input_cond_pkg: shared constants and types for the input conditioner.
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles to accept a level change (10 ms @ 100 MHz)
//   DEBOUNCE_CYCLES_SIM     : short debounce window for simulation
//   CNT_W_DEFAULT           : debounce counter width for the default window
//   PRESS_CNT_W             : width of the wrapping press counter
package input_cond_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
    localparam int unsigned CNT_W_DEFAULT           = 24;
    localparam int unsigned PRESS_CNT_W             = 8;

    typedef logic [PRESS_CNT_W-1:0] press_cnt_t;

endpackage : input_cond_pkg

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: bundles the raw inputs and conditioned outputs.
//   next_raw / in_raw       : raw asynchronous button / switch levels
//   next_clean / in_clean   : debounced levels
//   next_pulse              : one-cycle strobe per accepted press
//   press_count             : accepted presses modulo 256
// master: the side driving the raw inputs; slave: the conditioner.
interface input_conditioner_if
    import input_cond_pkg::*;
;
    logic       next_raw;
    logic       in_raw;
    logic       next_clean;
    logic       in_clean;
    logic       next_pulse;
    press_cnt_t press_count;

    modport master (
        output next_raw,
        output in_raw,
        input  next_clean,
        input  in_clean,
        input  next_pulse,
        input  press_count
    );

    modport slave (
        input  next_raw,
        input  in_raw,
        output next_clean,
        output in_clean,
        output next_pulse,
        output press_count
    );

endinterface : input_conditioner_if

// File: rtl/input_conditioner_debounce_filter.sv
// debounce_filter: 2-flop synchroniser followed by a stable-count debouncer.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   raw   : asynchronous, possibly bouncy input
//   level : debounced level (changes after DEBOUNCE_CYCLES stable cycles)
//   rise  : registered one-cycle strobe, high in the cycle after level goes 0->1
module debounce_filter
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             lvl_q;
    logic             lvl_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronised input agrees with the output level
    // restarts the count, so only an unbroken run of disagreement is accepted.
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            lvl_d  = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
        end
    end

    assign level = lvl_q;
    assign rise  = rise_q;

endmodule : debounce_filter

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the push-button and switch
// feeding the sequence detector, strobes each accepted press and counts them.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   cond  : slave side of input_conditioner_if
//           (next_raw, in_raw in; next_clean, in_clean, next_pulse, press_count out)
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input_conditioner_if.slave  cond
);

    logic       next_lvl;
    logic       next_rise;
    logic       in_lvl;
    logic       in_rise_unused;
    press_cnt_t press_q;
    press_cnt_t press_d;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_next_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (cond.next_raw),
        .level (next_lvl),
        .rise  (next_rise)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_in_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (cond.in_raw),
        .level (in_lvl),
        .rise  (in_rise_unused)
    );

    // press_q absorbs each strobe on the edge that ends it; adding the live
    // strobe on the output makes the visible count step on the same edge the
    // strobe is set, without exposing the filter's next-state logic.
    always_comb begin
        press_d = press_q + PRESS_CNT_W'(next_rise);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    assign cond.next_clean  = next_lvl;
    assign cond.in_clean    = in_lvl;
    assign cond.next_pulse  = next_rise;
    assign cond.press_count = press_d;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int unsigned N  = DEBOUNCE_CYCLES_SIM;
    localparam int unsigned CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    input_conditioner_if cif ();

    input_conditioner #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cond  (cif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       next_clean;
        logic       in_clean;
        logic       next_pulse;
        logic [7:0] press_count;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   obs_pulses = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // True when the last N synchroniser samples all disagree with lvl.
    // sh[0] is the newest sample; sh[N:1] is what the filter has seen at s2.
    function automatic logic window_differs(input logic [N:0] sh, input logic lvl);
        return sh[N:1] == {N{~lvl}};
    endfunction

    // Reference model: expected outputs after each edge are pushed here.
    initial begin : model
        logic [N:0] sh_n;
        logic [N:0] sh_i;
        logic       m_next;
        logic       m_in;
        logic       m_pulse;
        logic [7:0] m_cnt;
        sh_n    = '0;
        sh_i    = '0;
        m_next  = 1'b0;
        m_in    = 1'b0;
        m_pulse = 1'b0;
        m_cnt   = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                sh_n    = '0;
                sh_i    = '0;
                m_next  = 1'b0;
                m_in    = 1'b0;
                m_pulse = 1'b0;
                m_cnt   = '0;
                sb_q.delete();
                sb_q.push_back(exp_t'('0));
            end else begin
                m_pulse = 1'b0;
                if (window_differs(sh_n, m_next)) begin
                    m_next = ~m_next;
                    if (m_next) begin
                        m_pulse = 1'b1;
                        m_cnt   = m_cnt + 8'd1;
                    end
                end
                if (window_differs(sh_i, m_in)) m_in = ~m_in;
                sh_n = {sh_n[N-1:0], cif.next_raw};
                sh_i = {sh_i[N-1:0], cif.in_raw};
                sb_q.push_back(exp_t'{m_next, m_in, m_pulse, m_cnt});
            end
        end
    end

    // Scoreboard consumer: compare DUT outputs mid-cycle.
    initial begin : checker_proc
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("next_clean", 32'(cif.next_clean), 32'(e.next_clean));
                check_val("in_clean", 32'(cif.in_clean), 32'(e.in_clean));
                check_val("next_pulse", 32'(cif.next_pulse), 32'(e.next_pulse));
                check_val("press_count", 32'(cif.press_count), 32'(e.press_count));
            end
            if (cif.next_pulse === 1'b1) obs_pulses++;
        end
    end

    task automatic do_reset();
        cif.next_raw = 1'b0;
        cif.in_raw   = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts edges after E0 (the first edge after the stimulus) until the
    // chosen level reaches target; 0 means it never did within the bound.
    task automatic measure(input bit ch, input logic target, input string tag);
        int got;
        got = 0;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if ((ch ? cif.in_clean : cif.next_clean) === target) begin
                got = i;
                break;
            end
        end
        check_val(tag, 32'(got), 32'(N + 1));
    endtask

    task automatic settle_and_check(input string tag, input int p0, input int exp_pulses,
                                    input int exp_count);
        repeat (3) @(negedge clk);
        #1;
        check_val({tag, "_pulses"}, 32'(obs_pulses - p0), 32'(exp_pulses));
        check_val({tag, "_count"}, 32'(cif.press_count), 32'(exp_count));
    endtask

    initial begin : stim
        int         p0;
        logic [8:0] bounce;
        cif.next_raw = 1'b1;
        cif.in_raw   = 1'b1;

        // 1: reset with both raw inputs high, then press through release
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_next_clean", 32'(cif.next_clean), 32'd0);
        check_val("rst_in_clean", 32'(cif.in_clean), 32'd0);
        check_val("rst_count", 32'(cif.press_count), 32'd0);
        p0 = obs_pulses;
        @(negedge clk);
        reset = 1'b0;
        measure(1'b0, 1'b1, "s1_rise_lat");
        settle_and_check("s1", p0, 1, 1);

        // 2: clean press and release
        do_reset();
        p0 = obs_pulses;
        @(negedge clk);
        cif.next_raw = 1'b1;
        measure(1'b0, 1'b1, "s2_rise_lat");
        repeat (13) @(negedge clk);
        cif.next_raw = 1'b0;
        measure(1'b0, 1'b0, "s2_fall_lat");
        settle_and_check("s2", p0, 1, 1);

        // 3: bounce never reaches the output
        do_reset();
        p0 = obs_pulses;
        bounce = 9'b0_1110_1101;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cif.next_raw = bounce[i];
        end
        @(negedge clk);
        cif.next_raw = 1'b0;
        repeat (10) @(negedge clk);
        check_val("s3_next_clean", 32'(cif.next_clean), 32'd0);
        settle_and_check("s3", p0, 0, 0);

        // 4: switch path, short then long high
        @(negedge clk);
        cif.in_raw = 1'b1;
        repeat (3) @(negedge clk);
        cif.in_raw = 1'b0;
        repeat (10) @(negedge clk);
        check_val("s4_short_in", 32'(cif.in_clean), 32'd0);
        cif.in_raw = 1'b1;
        measure(1'b1, 1'b1, "s4_in_rise_lat");
        repeat (3) @(negedge clk);
        cif.in_raw = 1'b0;
        measure(1'b1, 1'b0, "s4_in_fall_lat");

        // 5: 257 presses wrap the counter to 1
        do_reset();
        p0 = obs_pulses;
        for (int k = 0; k < 257; k++) begin
            @(negedge clk);
            cif.next_raw = 1'b1;
            repeat (8) @(negedge clk);
            cif.next_raw = 1'b0;
            repeat (8) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        settle_and_check("s5_wrap", p0, 257, 1);

        // 6: asynchronous reset in the middle of a count
        @(negedge clk);
        cif.next_raw = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("s6_async_count", 32'(cif.press_count), 32'd0);
        check_val("s6_async_next", 32'(cif.next_clean), 32'd0);
        check_val("s6_async_pulse", 32'(cif.next_pulse), 32'd0);
        p0 = obs_pulses;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        measure(1'b0, 1'b1, "s6_rise_lat");
        settle_and_check("s6", p0, 1, 1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_input_conditioner

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the sequence-detector FSM. It takes the raw asynchronous push-button (`next_raw`) and slide-switch (`in_raw`) signals, synchronises and debounces them, and produces the clean `next_clean`/`in_clean` levels that drive the detector's `next`/`in` inputs. It also emits a one-cycle `next_pulse` on each accepted press and keeps a wrapping press counter for display.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Legal range is 2 to 2^24-1.
- `CNT_W`, default 24: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `next_raw`  input  1  raw push-button, asynchronous to `clk`, bouncy.
- `in_raw`  input  1  raw switch, asynchronous to `clk`, bouncy.
- `next_clean`  output  1  debounced button level; feeds detector `next`.
- `in_clean`  output  1  debounced switch level; feeds detector `in`.
- `next_pulse`  output  1  high for exactly one cycle per accepted 0->1 transition of `next_clean`.
- `press_count`  output  8  number of accepted presses, modulo 256.

## Operation
- Each channel (next, in) runs the same filter independently.
  - Stage 1: a 2-flop synchroniser (`s1`, `s2`).
  - Stage 2: a debounce counter `cnt` [CNT_W-1:0] and a registered output level `lvl`.
- Filter rule, evaluated every cycle:
  - If `s2 == lvl`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- The same rule applies to rising and falling changes.
- Any single-cycle disagreement between `s2` and `lvl` that ends before the count completes clears `cnt`. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the output.
- `next_pulse` is registered. It is set at the same edge where `next_clean` flips 0->1 and cleared on the following edge. A falling transition produces no pulse.
- `press_count` increments at the edge where `next_pulse` is set. It wraps 255 -> 0 with no saturation and no flag.
- Simultaneous changes on both channels are handled independently. `in_clean` may change at the same edge as `next_pulse` rises. The downstream FSM samples `in` one edge later, so it sees the new `in_clean` value; no ordering guarantee beyond this.
- Reset (asynchronous, any time, including mid-count):
  - Synchroniser flops, `cnt`, `next_clean`, `in_clean`, `next_pulse` and `press_count` all go to 0 immediately.
  - If `next_raw` is held high through reset release, it is debounced as a new press and produces one `next_pulse`.

## Timing
- Reset values: every output is 0.
- Latency from a clean raw step (stable before edge E0) to the output level change: the change appears at edge E0 + DEBOUNCE_CYCLES + 1.
  - `s2` updates at E0+1.
  - `cnt` counts 0..DEBOUNCE_CYCLES-1 over the next DEBOUNCE_CYCLES edges.
- `next_pulse` is high during exactly one cycle, the one beginning at the edge where `next_clean` rises.
- Maximum accepted press rate is one press per 2·DEBOUNCE_CYCLES cycles (high period plus low period).
- No handshake: the outputs are free-running levels and strobes; the consumer does its own edge detection.

## Structure
- Shared package `input_cond_pkg`:
  - `DEBOUNCE_CYCLES_DEFAULT` = 1_000_000
  - `DEBOUNCE_CYCLES_SIM` = 4
  - `CNT_W_DEFAULT` = 24
  - `PRESS_CNT_W` = 8
- Sub-module `debounce_filter` (parameters `DEBOUNCE_CYCLES`, `CNT_W`; ports `clk`, `reset`, `raw`, `level`, `rise`). It contains the synchroniser, counter and level register, and is instantiated twice.
- The top level adds the `press_count` register and output wiring.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset values: assert `reset` with both raw inputs at 1 -> all outputs are 0 while `reset` is high. After release, `next_clean` rises exactly 5 edges later, with one `next_pulse` and `press_count`=1.
2. Clean press: `next_raw` 0->1 held 20 cycles, then 0 -> `next_clean` rises at E0+5 and `next_pulse` is high for exactly 1 cycle. The fall occurs 5 edges after `next_raw` drops, with no pulse. `press_count`=1.
3. Bounce rejection: `next_raw` toggles 1,0,1,1,0,1,1,1,0 (one value per cycle), then stays 0 -> `next_clean` stays 0, no pulse, `press_count`=0.
4. Switch path: `in_raw` held 1 for 3 cycles then 0 -> `in_clean` stays 0. `in_raw` held 1 for 10 cycles -> `in_clean`=1 from E0+5.
5. Wrap: 257 clean presses -> `press_count` reads 1 and exactly 257 `next_pulse` strobes are counted.
6. Reset mid-count: raise `next_raw`, assert `reset` asynchronously after 3 cycles (between edges), release, hold `next_raw` -> outputs clear immediately, and `next_clean` rises 5 edges after release, not earlier.
